// File: rtl/minmax_scanner.sv
// Scans NUM_SAMPLES unsigned 4-bit samples and reports the max, the min and the
// first index of each. Define MINMAX_TIE_COUNT_EN to add max_cnt (samples equal to max).
module minmax_scanner #(
    parameter int NUM_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] max_val,
    output logic [3:0] min_val,
    output logic [3:0] max_idx,
    output logic [3:0] min_idx
`ifdef MINMAX_TIE_COUNT_EN
    ,
    output logic [3:0] max_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(NUM_SAMPLES - 1);

    state_e     state_q,       state_d;
    logic [3:0] cnt_q,         cnt_d;
    logic [3:0] run_max_q,     run_max_d;
    logic [3:0] run_min_q,     run_min_d;
    logic [3:0] run_max_idx_q, run_max_idx_d;
    logic [3:0] run_min_idx_q, run_min_idx_d;
    logic [3:0] max_val_q,     max_val_d;
    logic [3:0] min_val_q,     min_val_d;
    logic [3:0] max_idx_q,     max_idx_d;
    logic [3:0] min_idx_q,     min_idx_d;
`ifdef MINMAX_TIE_COUNT_EN
    logic [3:0] run_tie_q,     run_tie_d;
    logic [3:0] max_cnt_q,     max_cnt_d;
`endif

    // NOTE: every variable gets its hold value first so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        run_max_idx_d = run_max_idx_q;
        run_min_idx_d = run_min_idx_q;
        max_val_d     = max_val_q;
        min_val_d     = min_val_q;
        max_idx_d     = max_idx_q;
        min_idx_d     = min_idx_q;
`ifdef MINMAX_TIE_COUNT_EN
        run_tie_d     = run_tie_q;
        max_cnt_d     = max_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end

            SCAN: begin
                // abort wins over a sample presented in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (cnt_q == '0) begin
                        run_max_d     = in_data;
                        run_min_d     = in_data;
                        run_max_idx_d = '0;
                        run_min_idx_d = '0;
`ifdef MINMAX_TIE_COUNT_EN
                        run_tie_d     = 4'd1;
`endif
                    end else begin
                        if (in_data > run_max_q) begin
                            run_max_d     = in_data;
                            run_max_idx_d = cnt_q;
`ifdef MINMAX_TIE_COUNT_EN
                            run_tie_d     = 4'd1;
                        end else if (in_data == run_max_q) begin
                            // a 16-sample all-equal scan saturates at 15
                            if (run_tie_q != 4'hF) run_tie_d = run_tie_q + 4'd1;
`endif
                        end
                        if (in_data < run_min_q) begin
                            run_min_d     = in_data;
                            run_min_idx_d = cnt_q;
                        end
                    end

                    if (cnt_q == LAST_IDX) begin
                        state_d   = DONE;
                        max_val_d = run_max_d;
                        min_val_d = run_min_d;
                        max_idx_d = run_max_idx_d;
                        min_idx_d = run_min_idx_d;
`ifdef MINMAX_TIE_COUNT_EN
                        max_cnt_d = run_tie_d;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the running and result registers are reset too because
    // the outputs must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            run_max_idx_q <= '0;
            run_min_idx_q <= '0;
            max_val_q     <= '0;
            min_val_q     <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
`ifdef MINMAX_TIE_COUNT_EN
            run_tie_q     <= '0;
            max_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            run_max_idx_q <= run_max_idx_d;
            run_min_idx_q <= run_min_idx_d;
            max_val_q     <= max_val_d;
            min_val_q     <= min_val_d;
            max_idx_q     <= max_idx_d;
            min_idx_q     <= min_idx_d;
`ifdef MINMAX_TIE_COUNT_EN
            run_tie_q     <= run_tie_d;
            max_cnt_q     <= max_cnt_d;
`endif
        end
    end

    assign in_ready = (state_q == SCAN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign max_val  = max_val_q;
    assign min_val  = min_val_q;
    assign max_idx  = max_idx_q;
    assign min_idx  = min_idx_q;
`ifdef MINMAX_TIE_COUNT_EN
    assign max_cnt  = max_cnt_q;
`endif

endmodule

// File: tb/tb_minmax_scanner.sv
// Self-checking bench for minmax_scanner: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random scans.
module tb_minmax_scanner;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_ready, busy, done;
    logic [3:0] max_val, min_val, max_idx, min_idx;
`ifdef MINMAX_TIE_COUNT_EN
    logic [3:0] max_cnt;
`endif

    minmax_scanner #(.NUM_SAMPLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .min_val  (min_val),
        .max_idx  (max_idx),
        .min_idx  (min_idx)
`ifdef MINMAX_TIE_COUNT_EN
        ,
        .max_cnt  (max_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is just the list of accepted samples; results
    // are computed from that list once it is full.
    bit         m_scan = 1'b0;
    bit         m_done = 1'b0;
    int         m_q[$];
    logic [3:0] m_max = 4'd0, m_min = 4'd0, m_max_idx = 4'd0, m_min_idx = 4'd0, m_cnt = 4'd0;

    function automatic void finish_scan();
        int mx, mi, xi, ni, c;
        mx = m_q[0]; mi = m_q[0]; xi = 0; ni = 0; c = 0;
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i] > mx) begin mx = m_q[i]; xi = i; end
            if (m_q[i] < mi) begin mi = m_q[i]; ni = i; end
        end
        foreach (m_q[i]) if (m_q[i] == mx) c++;
        if (c > 15) c = 15;
        m_max = 4'(mx); m_min = 4'(mi); m_max_idx = 4'(xi); m_min_idx = 4'(ni); m_cnt = 4'(c);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_scan = 1'b0; m_done = 1'b0; m_q.delete();
            m_max = 4'd0; m_min = 4'd0; m_max_idx = 4'd0; m_min_idx = 4'd0; m_cnt = 4'd0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_scan) begin
            if (start && !abort) begin m_scan = 1'b1; m_q.delete(); end
        end else if (abort) begin
            m_scan = 1'b0; m_q.delete();
        end else if (in_valid) begin
            m_q.push_back(int'(in_data));
            if (m_q.size() == N) begin
                finish_scan();
                m_scan = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 4'(in_ready), 4'(m_scan));
            check("busy",     4'(busy),     4'(m_scan | m_done));
            check("done",     4'(done),     4'(m_done));
            check("max_val",  max_val, m_max);
            check("min_val",  min_val, m_min);
            check("max_idx",  max_idx, m_max_idx);
            check("min_idx",  min_idx, m_min_idx);
`ifdef MINMAX_TIE_COUNT_EN
            check("max_cnt",  max_cnt, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input int s[N], input bit stall);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_data = 4'(s[i]); step();
            in_valid = 1'b0;
            if (stall && i != N - 1) step();
        end
        check("done_pulse", 4'(done), 4'd1);
        step();
        check("done_low", 4'(done), 4'd0);
    endtask

    task automatic check_results(input string tag, input logic [3:0] mx, input logic [3:0] xi,
                                 input logic [3:0] mn, input logic [3:0] ni, input logic [3:0] c);
        check({tag, "_max"},     max_val, mx);
        check({tag, "_max_idx"}, max_idx, xi);
        check({tag, "_min"},     min_val, mn);
        check({tag, "_min_idx"}, min_idx, ni);
`ifdef MINMAX_TIE_COUNT_EN
        check({tag, "_cnt"},     max_cnt, c);
`else
        if (c != 4'd0) check({tag, "_cnt_absent"}, 4'd0, 4'd0 & c);
`endif
    endtask

    int basic[N] = '{3, 9, 1, 12, 7, 0, 5, 12};
    int equal[N] = '{6, 6, 6, 6, 6, 6, 6, 6};
    int desc[N]  = '{15, 14, 13, 12, 11, 10, 9, 8};

    initial begin
        int guard;

        // reset state
        step(); step();
        chk_en = 1'b1;
        check("rst_busy", 4'(busy), 4'd0);
        check("rst_ready", 4'(in_ready), 4'd0);
        check_results("rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1; step();

        // basic, stalled and all-equal scans
        run_scan(basic, 1'b0);
        check_results("basic", 4'd12, 4'd3, 4'd0, 4'd5, 4'd2);
        run_scan(basic, 1'b1);
        check_results("stall", 4'd12, 4'd3, 4'd0, 4'd5, 4'd2);
        run_scan(equal, 1'b0);
        check_results("equal", 4'd6, 4'd0, 4'd6, 4'd0, 4'd8);

        // abort after 4 samples; the sample in the abort cycle is dropped
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin in_valid = 1'b1; in_data = 4'(desc[i]); step(); end
        abort = 1'b1; in_data = 4'd0; step();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_idle", 4'(busy), 4'd0);
        check("abort_no_done", 4'(done), 4'd0);
        check_results("abort_keep", 4'd6, 4'd0, 4'd6, 4'd0, 4'd8);
        run_scan(desc, 1'b0);
        check_results("desc", 4'd15, 4'd0, 4'd8, 4'd7, 4'd1);

        // reset mid-scan, then start on the first cycle out of reset
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = 4'(basic[i]); step(); end
        in_valid = 1'b0; rst_n = 1'b0; step();
        check("rstmid_busy", 4'(busy), 4'd0);
        check("rstmid_done", 4'(done), 4'd0);
        check_results("rstmid", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1; start = 1'b1; step(); start = 1'b0;
        check("rst_restart", 4'(busy), 4'd1);
        for (int i = 0; i < N; i++) begin in_valid = 1'b1; in_data = 4'(equal[i]); step(); end
        in_valid = 1'b0; step();
        check_results("after_rst", 4'd6, 4'd0, 4'd6, 4'd0, 4'd8);

        // start pulses during SCAN and DONE are ignored
        start = 1'b1; step();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_data = 4'(basic[i]); start = (i % 2 == 0); step();
        end
        in_valid = 1'b0; start = 1'b1;
        check("ign_done", 4'(done), 4'd1);
        step(); start = 1'b0;
        check("ign_idle", 4'(busy), 4'd0);
        check_results("ign", 4'd12, 4'd3, 4'd0, 4'd5, 4'd2);

        // abort and start together in IDLE: stays idle
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        check("abort_start", 4'(busy), 4'd0);

        // random scans with stalls, stray starts and occasional aborts
        for (int s = 0; s < 40; s++) begin
            start = 1'b1; step(); start = 1'b0;
            guard = 0;
            while (m_scan && guard < 200) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 4'($urandom_range(0, 15));
                abort    = ($urandom_range(0, 29) == 0);
                start    = ($urandom_range(0, 3) == 0);
                step();
                guard++;
            end
            in_valid = 1'b0; abort = 1'b0; start = 1'b0;
            if (guard >= 200) begin
                n_tests++; n_fail++;
                $display("FAIL rand_timeout: scan %0d still busy after %0d cycles", s, guard);
            end
            step(); step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
